// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the multi-cycle shift unit.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra bit so the last partial step never wraps the counter.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift by k (0..STEP) positions with op-dependent fill.
module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic [XLEN-1:0]          din,
  input  logic [1:0]               op,
  input  logic [$clog2(STEP):0]    k,
  output logic [XLEN-1:0]          dout
);

  logic            fill;
  logic [2*XLEN-1:0] ext;

  // For SRA the data MSB is still the original sign bit on every step.
  always_comb begin
    fill = (op == OP_SRA) & din[XLEN-1];
    ext  = {{XLEN{fill}}, din};
    if (op == OP_SRL || op == OP_SRA) dout = XLEN'(ext >> k);
    else                              dout = din << k;
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit: STEP bits per clock, valid/ready on both sides.
module shift_unit
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [XLEN-1:0]          inp,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          res
);

  localparam int CW = cnt_width(XLEN);
  localparam int KW = $clog2(STEP) + 1;

  state_t          state;
  logic [XLEN-1:0] data;
  logic [XLEN-1:0] data_nxt;
  logic [CW-1:0]   count;
  logic [1:0]      op_q;
  logic [KW-1:0]   k;

  assign k = (count >= CW'(STEP)) ? KW'(STEP) : KW'(count);

  shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .din  (data),
    .op   (op_q),
    .k    (k),
    .dout (data_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      count <= '0;
      op_q  <= OP_SLL;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data  <= inp;
          op_q  <= op;
          count <= CW'(shamt);
          state <= SHIFT;
        end
        SHIFT: if (count == '0) begin
          state <= DONE;
        end else begin
          data  <= data_nxt;
          count <= count - CW'(k);
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign res       = data;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: three configs (32/1, 32/4, 64/8) against a reference model.
module tb_shift_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  ivalid = '0, ordy = '0, iready, ovalid;
  logic [1:0]  opv  [3];
  logic [63:0] inpv [3];
  logic [5:0]  shv  [3];
  logic [63:0] resv [3];
  logic [31:0] r0, r1;
  logic [63:0] r2;
  assign resv[0] = {32'b0, r0};
  assign resv[1] = {32'b0, r1};
  assign resv[2] = r2;

  int checks = 0, errors = 0;
  logic [63:0] exp_res [3];
  bit          exp_act [3];

  shift_unit #(.XLEN(32), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(ivalid[0]), .in_ready(iready[0]), .op(opv[0]),
    .inp(inpv[0][31:0]), .shamt(shv[0][4:0]), .out_valid(ovalid[0]), .out_ready(ordy[0]), .res(r0));
  shift_unit #(.XLEN(32), .STEP(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(ivalid[1]), .in_ready(iready[1]), .op(opv[1]),
    .inp(inpv[1][31:0]), .shamt(shv[1][4:0]), .out_valid(ovalid[1]), .out_ready(ordy[1]), .res(r1));
  shift_unit #(.XLEN(64), .STEP(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(ivalid[2]), .in_ready(iready[2]), .op(opv[2]),
    .inp(inpv[2]), .shamt(shv[2]), .out_valid(ovalid[2]), .out_ready(ordy[2]), .res(r2));

  function automatic int xl(input int u);  return (u == 2) ? 64 : 32; endfunction
  function automatic int stp(input int u); return (u == 0) ? 1 : (u == 1) ? 4 : 8; endfunction

  // Single-cycle reference shift.
  function automatic logic [63:0] model(input int xlen, input logic [1:0] o,
                                        input logic [63:0] x, input int sh);
    logic [31:0] a, r32;
    logic [63:0] r64;
    a = x[31:0];
    if (xlen == 32) begin
      case (o)
        2'b01:   r32 = a >> sh;
        2'b11:   r32 = $signed(a) >>> sh;
        default: r32 = a << sh;
      endcase
      return {32'b0, r32};
    end
    case (o)
      2'b01:   r64 = x >> sh;
      2'b11:   r64 = $signed(x) >>> sh;
      default: r64 = x << sh;
    endcase
    return r64;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare: result stable and correct whenever out_valid, handshake flags exclusive.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        check("ready_valid_excl", 64'(iready[u] & ovalid[u]), 64'd0);
        if (ovalid[u] && exp_act[u]) check("res_vs_model", resv[u], exp_res[u]);
      end
    end
  end

  task automatic run_op(input int u, input logic [1:0] o, input logic [63:0] x, input int sh,
                        input int hold, input bit noise, output logic [63:0] got, output int lat);
    int  el;
    bit  seen;
    @(negedge clk);
    check("in_ready_idle", 64'(iready[u]), 64'd1);
    ivalid[u] = 1'b1; opv[u] = o; inpv[u] = x; shv[u] = 6'(sh);
    @(posedge clk); #1;
    ivalid[u]    = 1'b0;
    exp_res[u]   = model(xl(u), o, x, sh);
    exp_act[u]   = 1'b1;
    el   = 1 + (sh + stp(u) - 1) / stp(u);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      ivalid[u] = 1'b0;
      if (ovalid[u]) seen = 1'b1;
      else if (noise) begin
        ivalid[u] = 1'b1; inpv[u] = {$urandom, $urandom}; opv[u] = 2'($urandom); shv[u] = 6'($urandom);
      end
    end
    check("out_valid_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), 64'(el));
    got = resv[u];
    for (int i = 0; i < hold; i++) begin
      ivalid[u] = noise;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 64'(ovalid[u]), 64'd1);
      check("hold_res", resv[u], got);
    end
    ordy[u] = 1'b1;
    ivalid[u] = noise;
    @(posedge clk); #1;
    ordy[u] = 1'b0; exp_act[u] = 1'b0;
    check("post_hs_in_ready", 64'(iready[u]), 64'd1);
    check("post_hs_out_valid", 64'(ovalid[u]), 64'd0);
    ivalid[u] = 1'b0;
  endtask

  initial begin
    logic [63:0] g;
    int l;
    for (int u = 0; u < 3; u++) begin
      opv[u] = '0; inpv[u] = '0; shv[u] = '0; exp_res[u] = '0; exp_act[u] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst_in_ready", 64'(iready[u]), 64'd1);
      check("rst_out_valid", 64'(ovalid[u]), 64'd0);
      check("rst_res", resv[u], 64'd0);
    end
    rst = 1'b0;

    // Hand-computed expectations.
    run_op(0, 2'b00, 64'h1, 8, 0, 1'b0, g, l);
    check("sll_1_8", g, 64'h100); check("sll_1_8_lat", 64'(l), 64'd9);
    run_op(0, 2'b11, 64'h80000000, 31, 0, 1'b0, g, l);
    check("sra_sign", g, 64'hFFFFFFFF); check("sra_lat", 64'(l), 64'd32);
    run_op(0, 2'b01, 64'h80000000, 31, 0, 1'b0, g, l);
    check("srl_msb", g, 64'h1);
    run_op(0, 2'b01, 64'h5, 0, 0, 1'b0, g, l);
    check("zero_shift", g, 64'h5); check("zero_shift_lat", 64'(l), 64'd1);
    run_op(0, 2'b10, 64'h5, 10, 0, 1'b0, g, l);
    check("reserved_op", g, 64'h1400);
    run_op(1, 2'b00, 64'hDEADBEEF, 10, 0, 1'b0, g, l);
    check("step4_sll", g, 64'hB6FBBC00); check("step4_lat", 64'(l), 64'd4);
    run_op(2, 2'b01, 64'hF000000000000000, 60, 0, 1'b0, g, l);
    check("x64_srl", g, 64'hF); check("x64_lat", 64'(l), 64'd9);
    run_op(2, 2'b11, 64'h8000000000000000, 63, 0, 1'b0, g, l);
    check("x64_sra", g, 64'hFFFFFFFFFFFFFFFF);

    // Back-pressure with ignored in_valid pulses in SHIFT and DONE.
    run_op(0, 2'b11, 64'hF0F00000, 12, 5, 1'b1, g, l);
    check("bp_res", g, 64'hFFFF0F00);

    // Reset mid-SHIFT discards the operation.
    @(negedge clk);
    ivalid[0] = 1'b1; opv[0] = 2'b00; inpv[0] = 64'h3; shv[0] = 6'd20;
    @(posedge clk); #1; ivalid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    check("midrst_out_valid", 64'(ovalid[0]), 64'd0);
    check("midrst_in_ready", 64'(iready[0]), 64'd1);
    check("midrst_res", resv[0], 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(0, 2'b01, 64'hABCD0000, 16, 1, 1'b0, g, l);
    check("after_rst", g, 64'hABCD);

    // Randomized against the model (model checks done by the compare process).
    for (int n = 0; n < 1000; n++)
      run_op(1, 2'($urandom), {32'b0, $urandom}, $urandom_range(0, 31), $urandom_range(0, 2), (n % 8) == 0, g, l);
    for (int n = 0; n < 250; n++)
      run_op(0, 2'($urandom), {32'b0, $urandom}, $urandom_range(0, 31), $urandom_range(0, 2), (n % 8) == 0, g, l);
    for (int n = 0; n < 250; n++)
      run_op(2, 2'($urandom), {$urandom, $urandom}, $urandom_range(0, 63), $urandom_range(0, 2), (n % 8) == 0, g, l);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
